// File: rtl/sync_down_counter_if.sv
// ---------------------------------------------------------------------------
// sync_down_counter_if
//   Bundles the control inputs and status outputs of sync_down_counter.
//
//   Handshake: there is no valid/ready pair. load and en are single-cycle
//   strobes sampled on every rising clock edge. load_val is only looked at
//   while load is high. All outputs are registered (zero is decoded from
//   the registered count) and may be used directly as synchronous enables.
//
//   Signals:
//     load       master->slave  parallel load strobe
//     load_val   master->slave  value captured on load (WIDTH bits)
//     en         master->slave  count enable
//     cnt        slave->master  current count (WIDTH bits)
//     zero       slave->master  cnt == 0
//     tc         slave->master  one-cycle terminal-count pulse
//     busy       slave->master  counter is in RUN
//     state_dbg  slave->master  raw FSM state (debug/observation only)
// ---------------------------------------------------------------------------
interface sync_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] cnt;
    logic             zero;
    logic             tc;
    logic             busy;
    logic [1:0]       state_dbg;

    modport master (
        output load, load_val, en,
        input  cnt, zero, tc, busy, state_dbg
    );

    modport slave (
        input  load, load_val, en,
        output cnt, zero, tc, busy, state_dbg
    );
endinterface

// File: rtl/sync_down_counter.sv
// ---------------------------------------------------------------------------
// sync_down_counter
//   Single-clock down-counter/timer with parallel load, count enable,
//   registered terminal-count pulse and optional auto-reload.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    sync_down_counter_if.slave (load, load_val, en in;
//            cnt, zero, tc, busy, state_dbg out)
//
//   Build option:
//     DOWN_CNT_RELOAD_EN  defined   -> terminal event reloads cnt from the
//                                      reload register and stays in RUN
//                                      (periodic divide-by-N)
//                         undefined -> terminal event clears cnt and parks
//                                      in DONE (one-shot)
// ---------------------------------------------------------------------------
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_down_counter_if.slave  bus
);

`ifdef DOWN_CNT_RELOAD_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            // Load wins over en in every state, even at cnt == 1, so a
            // load coincident with the terminal edge never produces tc.
            reload_d = bus.load_val;
            cnt_d    = bus.load_val;
            state_d  = (bus.load_val != '0) ? RUN : IDLE;
        end else if ((state_q == RUN) && bus.en) begin
            if (cnt_q == ONE) begin
                // Terminal event replaces the 1 -> 0 step.
                tc_d = 1'b1;
`ifdef DOWN_CNT_RELOAD_EN
                cnt_d = reload_q;
`else
                cnt_d   = '0;
                state_d = DONE;
`endif
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end

        // busy is registered alongside the state so it tracks RUN exactly.
        busy_d = (state_d == RUN);
    end

    assign bus.cnt       = cnt_q;
    assign bus.zero      = (cnt_q == '0);
    assign bus.tc        = tc_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sync_down_counter.sv
module tb_sync_down_counter;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 3;   // {cnt, tc, busy, zero}

  logic clk;
  logic rst_n;

  sync_down_counter_if #(.WIDTH(WIDTH)) bus ();

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             busy;
    logic             zero;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ld, input int val, input logic e,
                              input int c, input logic t, input logic b,
                              input logic z);
    vec_t v;
    v.load     = ld;
    v.load_val = WIDTH'(val);
    v.en       = e;
    v.cnt      = WIDTH'(c);
    v.tc       = t;
    v.busy     = b;
    v.zero     = z;
    vecs.push_back(v);
  endfunction

  function automatic logic [W-1:0] pack(input int c, input logic t,
                                        input logic b, input logic z);
    logic [WIDTH-1:0] cc;
    cc = WIDTH'(c);
    return {cc, t, b, z};
  endfunction

  // Compare current DUT outputs against an expected packed value.
  task automatic check_out(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = {bus.cnt, bus.tc, bus.busy, bus.zero};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d tc=%b busy=%b zero=%b, expected cnt=%0d tc=%b busy=%b zero=%b",
               name, act[W-1:3], act[2], act[1], act[0],
               exp[W-1:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, push the expectation, sample #1 after the
  // rising edge and compare against the popped scoreboard entry.
  task automatic apply(input string name, input logic ld,
                       input logic [WIDTH-1:0] val, input logic e,
                       input logic [W-1:0] exp);
    @(negedge clk);
    bus.load     = ld;
    bus.load_val = val;
    bus.en       = e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_out(name, exp_q.pop_front());
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold", pack(0, 0, 0, 1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("reset_release", pack(0, 0, 0, 1));
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;

    // Async reset must take effect without any clock edge.
    #2;
    check_out("reset_async_initial", pack(0, 0, 0, 1));
    do_reset();

`ifdef DOWN_CNT_RELOAD_EN
    // auto-reload: load 3, nine enabled edges
    add(1, 3, 0,  3, 0, 1, 0);
    add(0, 0, 1,  2, 0, 1, 0);
    add(0, 0, 1,  1, 0, 1, 0);
    add(0, 0, 1,  3, 1, 1, 0);
    add(0, 0, 1,  2, 0, 1, 0);
    add(0, 0, 1,  1, 0, 1, 0);
    add(0, 0, 1,  3, 1, 1, 0);
    add(0, 0, 1,  2, 0, 1, 0);
    add(0, 0, 1,  1, 0, 1, 0);
    add(0, 0, 1,  3, 1, 1, 0);
    // reload of 1: load 15, count a bit, then load 1
    add(1, 15, 0, 15, 0, 1, 0);
    add(0, 0, 1,  14, 0, 1, 0);
    add(0, 0, 1,  13, 0, 1, 0);
    add(0, 0, 1,  12, 0, 1, 0);
    add(1, 1, 1,  1, 0, 1, 0);
    add(0, 0, 1,  1, 1, 1, 0);
    add(0, 0, 1,  1, 1, 1, 0);
    add(0, 0, 1,  1, 1, 1, 0);
    add(0, 0, 0,  1, 0, 1, 0);
`else
    // one-shot: load 4, en held
    add(1, 4, 0,  4, 0, 1, 0);
    add(0, 0, 1,  3, 0, 1, 0);
    add(0, 0, 1,  2, 0, 1, 0);
    add(0, 0, 1,  1, 0, 1, 0);
    add(0, 0, 1,  0, 1, 0, 1);
    add(0, 0, 1,  0, 0, 0, 1);
    add(0, 0, 1,  0, 0, 0, 1);
    // enable gaps from DONE: load 3, en 1,0,0,1,1
    add(1, 3, 0,  3, 0, 1, 0);
    add(0, 0, 1,  2, 0, 1, 0);
    add(0, 0, 0,  2, 0, 1, 0);
    add(0, 0, 0,  2, 0, 1, 0);
    add(0, 0, 1,  1, 0, 1, 0);
    add(0, 0, 1,  0, 1, 0, 1);
`endif
    // load priority (common to both builds)
    add(1, 2, 0,  2, 0, 1, 0);
    add(0, 0, 1,  1, 0, 1, 0);
    add(1, 9, 1,  9, 0, 1, 0);
    add(1, 0, 1,  0, 0, 0, 1);
    add(0, 0, 1,  0, 0, 0, 1);
    add(1, 0, 0,  0, 0, 0, 1);

    foreach (vecs[i]) begin
      apply($sformatf("vec%0d", i), vecs[i].load, vecs[i].load_val, vecs[i].en,
            {vecs[i].cnt, vecs[i].tc, vecs[i].busy, vecs[i].zero});
    end
    idle_inputs();

    // Latency from load(N) with en held: tc after exactly N enabled edges.
    for (int r = 0; r < 3; r++) begin
      int n;
      int edges;
      bit seen;
      n = $urandom_range(2, 15);
      apply($sformatf("lat_load%0d", r), 1'b1, WIDTH'(n), 1'b0, pack(n, 0, 1, 0));
      @(negedge clk);
      bus.load = 1'b0;
      bus.en   = 1'b1;
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 20) begin
        @(posedge clk);
        #1;
        edges++;
        if (bus.tc === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || edges != n) begin
        errors++;
        $display("FAIL latency_n%0d: tc after %0d edges (seen=%0b), expected %0d",
                 n, edges, seen, n);
      end
`ifdef DOWN_CNT_RELOAD_EN
      check_out($sformatf("lat_term%0d", r), pack(n, 1, 1, 0));
`else
      check_out($sformatf("lat_term%0d", r), pack(0, 1, 0, 1));
`endif
      idle_inputs();
    end

    // Reset mid-count at cnt=5, between edges.
    apply("mid_load6", 1'b1, WIDTH'(6), 1'b0, pack(6, 0, 1, 0));
    apply("mid_dec5",  1'b0, '0,        1'b1, pack(5, 0, 1, 0));
    @(negedge clk);
    bus.en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_out("mid_reset_async", pack(0, 0, 0, 1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_out("mid_reset_after", pack(0, 0, 0, 1));

    // Reset while tc is high clears the pending pulse immediately.
    apply("tc_load1", 1'b1, WIDTH'(1), 1'b0, pack(1, 0, 1, 0));
`ifdef DOWN_CNT_RELOAD_EN
    apply("tc_term", 1'b0, '0, 1'b1, pack(1, 1, 1, 0));
`else
    apply("tc_term", 1'b0, '0, 1'b1, pack(0, 1, 0, 1));
`endif
    #1 rst_n = 1'b0;
    #1 check_out("tc_reset_async", pack(0, 0, 0, 1));
    @(negedge clk);
    bus.en = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1 check_out("tc_reset_after", pack(0, 0, 0, 1));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
